mlp_layer_sequencer: RTL and testbench

MLP_LAYER_SEQUENCER -- requirements
Module: mlp_layer_sequencer

---
 rtl/mlp_pkg.sv | 19 +
 rtl/mlp_idx_counter.sv | 43 ++++
 rtl/mlp_layer_sequencer.sv | 165 ++++++++++++++++
 tb/tb_mlp_layer_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared constants and the sequencer state type for the MLP inference datapath.
package mlp_pkg;
    localparam int L0_DEF     = 784;
    localparam int L1_DEF     = 32;
    localparam int L2_DEF     = 32;
    localparam int L3_DEF     = 10;
    localparam int W_AW_DEF   = 15;
    localparam int B_AW_DEF   = 7;
    localparam int ACT_W      = 10;
    localparam int WR_W       = 7;
    localparam int NUM_LAYERS = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        NRN  = 2'd2,
        FIN  = 2'd3
    } state_e;
endpackage

// File: rtl/mlp_idx_counter.sv
// Nested input/neuron counter for one weight layer; both indices wrap to zero after their last value.
module mlp_idx_counter #(
    parameter int FAN_IN  = 2,
    parameter int NEURONS = 2,
    parameter int CW      = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_k_i,
    input  logic          inc_n_i,
    output logic [CW-1:0] k_o,
    output logic          k_last_o,
    output logic          n_last_o
);
    logic [CW-1:0] k_q, k_d, n_q, n_d;

    assign k_o      = k_q;
    assign k_last_o = (k_q == CW'(FAN_IN - 1));
    assign n_last_o = (n_q == CW'(NEURONS - 1));

    always_comb begin
        k_d = k_q;
        n_d = n_q;
        if (clr_i) begin
            k_d = '0;
            n_d = '0;
        end else begin
            if (inc_k_i) k_d = k_last_o ? '0 : k_q + CW'(1);
            if (inc_n_i) n_d = n_last_o ? '0 : n_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0;
            n_q <= '0;
        end else begin
            k_q <= k_d;
            n_q <= n_d;
        end
    end
endmodule

// File: rtl/mlp_layer_sequencer.sv
// Walks every (layer, neuron, input) MAC beat of a 3-layer MLP, then hands each finished
// neuron to writeback; a layer's last writeback must complete before the next layer's first beat.
module mlp_layer_sequencer
    import mlp_pkg::*;
#(
    parameter int L0   = L0_DEF,
    parameter int L1   = L1_DEF,
    parameter int L2   = L2_DEF,
    parameter int L3   = L3_DEF,
    parameter int W_AW = W_AW_DEF,
    parameter int B_AW = B_AW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             beat_valid,
    input  logic             beat_ready,
    output logic [W_AW-1:0]  w_addr,
    output logic             act_sel,
    output logic [ACT_W-1:0] act_idx,
    output logic             beat_first,
    output logic             beat_last,
    output logic             nrn_valid,
    input  logic             nrn_ready,
    output logic [B_AW-1:0]  b_addr,
    output logic [WR_W-1:0]  wr_idx,
    output logic [1:0]       layer,
    output logic             relu_en
);
    localparam int CW    = $clog2(L0 + L1 + L2 + L3 + 1);
    localparam int TOT_W = L0 * L1 + L1 * L2 + L2 * L3;
    localparam int WW    = $clog2(TOT_W + 1);
    localparam int NW    = $clog2(L1 + L2 + L3 + 1);

    state_e                           state_q, state_d;
    logic [WW-1:0]                    w_q, w_d;
    logic [NW-1:0]                    nc_q, nc_d;
    logic [1:0]                       layer_q, layer_d;
    logic                             clr, beat_acc, nrn_acc;
    logic [NUM_LAYERS-1:0]            inc_k, inc_n, k_last, n_last;
    logic [NUM_LAYERS-1:0][CW-1:0]    k_arr;
    logic [CW-1:0]                    k_cur;
    logic                             k_last_cur, n_last_cur;

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_lyr
        localparam int FAN  = (g == 0) ? L0 : (g == 1) ? L1 : L2;
        localparam int NRNS = (g == 0) ? L1 : (g == 1) ? L2 : L3;
        mlp_idx_counter #(.FAN_IN(FAN), .NEURONS(NRNS), .CW(CW)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .clr_i    (clr),
            .inc_k_i  (inc_k[g]),
            .inc_n_i  (inc_n[g]),
            .k_o      (k_arr[g]),
            .k_last_o (k_last[g]),
            .n_last_o (n_last[g])
        );
    end

    always_comb begin
        k_cur      = k_arr[0];
        k_last_cur = k_last[0];
        n_last_cur = n_last[0];
        case (layer_q)
            2'd1: begin
                k_cur      = k_arr[1];
                k_last_cur = k_last[1];
                n_last_cur = n_last[1];
            end
            2'd2: begin
                k_cur      = k_arr[2];
                k_last_cur = k_last[2];
                n_last_cur = n_last[2];
            end
            default: ;
        endcase
        for (int i = 0; i < NUM_LAYERS; i++) begin
            inc_k[i] = beat_acc && (layer_q == 2'(i));
            inc_n[i] = nrn_acc && (layer_q == 2'(i));
        end
    end

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        nc_d     = nc_q;
        layer_d  = layer_q;
        clr      = 1'b0;
        beat_acc = 1'b0;
        nrn_acc  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = BEAT;
                w_d     = '0;
                nc_d    = '0;
                layer_d = '0;
                clr     = 1'b1;
            end
            BEAT: if (beat_ready) begin
                beat_acc = 1'b1;
                w_d      = w_q + WW'(1);
                if (k_last_cur) state_d = NRN;
            end
            NRN: if (nrn_ready) begin
                nrn_acc = 1'b1;
                nc_d    = nc_q + NW'(1);
                state_d = BEAT;
                if (n_last_cur) begin
                    if (layer_q == 2'd2) state_d = FIN;
                    else                 layer_d = layer_q + 2'd1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            nc_q    <= '0;
            layer_q <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            nc_q    <= nc_d;
            layer_q <= layer_d;
        end
    end

    // Outputs are forced low while rst is asserted, even before the first clock edge.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        beat_valid = 1'b0;
        nrn_valid  = 1'b0;
        w_addr     = '0;
        act_sel    = 1'b0;
        act_idx    = '0;
        beat_first = 1'b0;
        beat_last  = 1'b0;
        b_addr     = '0;
        wr_idx     = '0;
        layer      = '0;
        relu_en    = 1'b0;
        if (!rst) begin
            busy       = (state_q == BEAT) || (state_q == NRN);
            done       = (state_q == FIN);
            beat_valid = (state_q == BEAT);
            nrn_valid  = (state_q == NRN);
            w_addr     = W_AW'(w_q);
            act_sel    = (layer_q != 2'd0);
            act_idx    = ACT_W'(k_cur + ((layer_q == 2'd2) ? CW'(L1) : '0));
            beat_first = (state_q == BEAT) && (k_cur == '0);
            beat_last  = (state_q == BEAT) && k_last_cur;
            b_addr     = B_AW'(nc_q);
            wr_idx     = WR_W'(nc_q);
            layer      = layer_q;
            relu_en    = (layer_q != 2'd2);
        end
    end
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Scoreboarded bench: a small 3/2/2/2 instance under scripted and random handshakes, plus a
// default-size instance for full-run beat/writeback counts and latency.
module tb_mlp_layer_sequencer;
    localparam int S0 = 3, S1 = 2, S2 = 2, S3 = 2;
    localparam int N_BEATS = S0 * S1 + S1 * S2 + S2 * S3;
    localparam int N_NRNS  = S1 + S2 + S3;

    logic clk = 1'b0;
    logic rst, start, beat_ready, nrn_ready;
    logic busy, done, beat_valid, act_sel, beat_first, beat_last, nrn_valid, relu_en;
    logic [14:0] w_addr;
    logic [9:0]  act_idx;
    logic [6:0]  b_addr, wr_idx;
    logic [1:0]  layer;

    logic bstart, bready;
    logic b_busy, b_done, b_bvalid, b_act_sel, b_first, b_last, b_nvalid, b_relu;
    logic [14:0] b_waddr;
    logic [9:0]  b_actidx;
    logic [6:0]  b_baddr, b_wridx;
    logic [1:0]  b_layer;

    always #5 clk = ~clk;

    mlp_layer_sequencer #(.L0(S0), .L1(S1), .L2(S2), .L3(S3), .W_AW(15), .B_AW(7)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .w_addr(w_addr),
        .act_sel(act_sel), .act_idx(act_idx), .beat_first(beat_first), .beat_last(beat_last),
        .nrn_valid(nrn_valid), .nrn_ready(nrn_ready), .b_addr(b_addr), .wr_idx(wr_idx),
        .layer(layer), .relu_en(relu_en)
    );

    mlp_layer_sequencer u_big (
        .clk(clk), .rst(rst), .start(bstart), .busy(b_busy), .done(b_done),
        .beat_valid(b_bvalid), .beat_ready(bready), .w_addr(b_waddr),
        .act_sel(b_act_sel), .act_idx(b_actidx), .beat_first(b_first), .beat_last(b_last),
        .nrn_valid(b_nvalid), .nrn_ready(bready), .b_addr(b_baddr), .wr_idx(b_wridx),
        .layer(b_layer), .relu_en(b_relu)
    );

    typedef struct {
        int w; int sel; int idx; int first; int last; int lyr; int relu;
    } beat_t;

    beat_t bq[$];
    int    nq[$];
    int    exp_done = 0;
    int    vectors = 0;
    int    miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every beat in layer/neuron/input order, then that neuron's writeback.
    task automatic push_model();
        int fan[3];
        int nrn[3];
        int w, nc;
        fan = '{S0, S1, S2};
        nrn = '{S1, S2, S3};
        w = 0;
        nc = 0;
        for (int l = 0; l < 3; l++)
            for (int n = 0; n < nrn[l]; n++) begin
                for (int k = 0; k < fan[l]; k++) begin
                    beat_t b;
                    b.w = w; b.sel = (l != 0); b.idx = (l == 2) ? S1 + k : k;
                    b.first = (k == 0); b.last = (k == fan[l] - 1);
                    b.lyr = l; b.relu = (l != 2);
                    bq.push_back(b);
                    w++;
                end
                nq.push_back(nc);
                nc++;
            end
        exp_done++;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (beat_valid && nrn_valid) chk("beat_during_nrn", 1, 0);
            if (beat_valid) begin
                if (bq.size() == 0) chk("beat_unexpected", 1, 0);
                else begin
                    chk("w_addr", 64'(w_addr), 64'(bq[0].w));
                    chk("beat_ctl", {act_sel, act_idx, beat_first, beat_last, layer, relu_en, busy},
                        {1'(bq[0].sel), 10'(bq[0].idx), 1'(bq[0].first), 1'(bq[0].last),
                         2'(bq[0].lyr), 1'(bq[0].relu), 1'b1});
                    if (beat_ready) void'(bq.pop_front());
                end
            end
            if (nrn_valid) begin
                if (nq.size() == 0 || bq.size() != N_BEATS - expected_beats_done(nq.size()))
                    chk("nrn_order", 1, 0);
                else begin
                    chk("wr_idx", {b_addr, wr_idx, busy}, {7'(nq[0]), 7'(nq[0]), 1'b1});
                    if (nrn_ready) void'(nq.pop_front());
                end
            end
            if (done) begin
                chk("done_legal", {exp_done > 0, bq.size() == 0, nq.size() == 0}, 3'b111);
                if (exp_done > 0) exp_done--;
            end
        end
    end

    // Beats that must already have been accepted when the writeback with nrem entries left is shown.
    function automatic int expected_beats_done(input int nrem);
        int fan[3];
        int nrn[3];
        int idx, acc;
        fan = '{S0, S1, S2};
        nrn = '{S1, S2, S3};
        idx = N_NRNS - nrem;
        acc = 0;
        for (int l = 0; l < 3; l++)
            for (int n = 0; n < nrn[l]; n++) begin
                if (idx >= 0) acc += fan[l];
                idx--;
            end
        return acc;
    endfunction

    task automatic run_inference(input int mode, input bit check_lat);
        int i, stall;
        bit seen;
        start = 1'b1;
        push_model();
        @(posedge clk); #1;
        start = 1'b0;
        stall = 0;
        seen = 1'b0;
        for (i = 1; i < 2000; i++) begin
            case (mode)
                0: begin beat_ready = 1'b1; nrn_ready = 1'b1; end
                1: begin beat_ready = !(i >= 2 && i <= 4); nrn_ready = 1'b1; end
                2: begin
                    beat_ready = 1'b1;
                    nrn_ready  = 1'b1;
                    if (nrn_valid && wr_idx == 7'd1 && stall < 5) begin
                        nrn_ready = 1'b0;
                        stall++;
                    end
                end
                default: begin
                    beat_ready = ($urandom_range(0, 3) != 0);
                    nrn_ready  = ($urandom_range(0, 2) != 0);
                    start      = $urandom_range(0, 1);
                end
            endcase
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (!seen) chk("done_timeout", 0, 1);
        else if (check_lat) chk("latency", 64'(i + 1), 64'(1 + N_BEATS + N_NRNS + 1));
        if (mode == 2) chk("nrn_stall_cycles", 64'(stall), 64'd5);
        @(negedge clk);
        chk("idle_after_done", {busy, done, beat_valid, nrn_valid}, 4'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        int beats, nrns, last_w;
        bit seen;
        rst = 1'b1; start = 1'b1; beat_ready = 1'b0; nrn_ready = 1'b0;
        bstart = 1'b0; bready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_ctl", {busy, done, beat_valid, nrn_valid, beat_first, beat_last, act_sel, relu_en, layer}, 0);
            chk("rst_addr", {w_addr, act_idx, b_addr, wr_idx}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_no_start", {busy, beat_valid}, 2'b0);
        @(posedge clk); #1;

        run_inference(0, 1'b1);
        run_inference(1, 1'b0);
        run_inference(2, 1'b0);
        for (int r = 0; r < 6; r++) run_inference(3, 1'b0);

        // Abort in layer 1, then a clean restart.
        start = 1'b1; push_model();
        @(posedge clk); #1; start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 500 && !seen; c++) begin
            beat_ready = ($urandom_range(0, 3) != 0);
            nrn_ready  = ($urandom_range(0, 2) != 0);
            if (layer == 2'd1 && beat_valid) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!seen) chk("reach_layer1", 0, 1);
        rst = 1'b1; start = 1'b1;
        bq.delete(); nq.delete(); exp_done = 0;
        @(negedge clk);
        chk("abort_rst_ctl", {busy, done, beat_valid, nrn_valid, beat_first, beat_last, act_sel, relu_en, layer}, 0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_quiet", {busy, done, beat_valid}, 3'b0);
        end
        @(posedge clk); #1;
        run_inference(0, 1'b1);

        // Default-size instance, readies held high.
        bstart = 1'b1;
        @(posedge clk); #1;
        bstart = 1'b0;
        beats = 0; nrns = 0; last_w = -1; seen = 1'b0;
        for (int c = 1; c < 30000; c++) begin
            @(negedge clk);
            if (b_bvalid) begin beats++; last_w = int'(b_waddr); end
            if (b_nvalid) nrns++;
            if (b_done) begin
                seen = 1'b1;
                chk("big_latency", 64'(c + 1), 64'(1 + 26432 + 74 + 1));
                break;
            end
        end
        if (!seen) chk("big_done_timeout", 0, 1);
        chk("big_beats", 64'(beats), 64'd26432);
        chk("big_nrns", 64'(nrns), 64'd74);
        chk("big_last_waddr", 64'(last_w), 64'd26431);
        chk("leftover_beats", 64'(bq.size()), 0);
        chk("leftover_nrns", 64'(nq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
